// File: rtl/record_dispatcher.sv
// record_dispatcher: pulls records from the stream elements in strict ring order,
// hands them round-robin to the compression engines, and logs the engine order
// so the downstream merger can restore stream order.
module record_dispatcher #(
    parameter int NUM_SOURCES      = 4,
    parameter int NUM_ENGINES      = 2,
    parameter int RECORD_BYTES     = 34,
    parameter int COUNT_W          = 6,
    parameter int ORDER_FIFO_DEPTH = 8,
    parameter int ENG_IDX_W        = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_SOURCES*RECORD_BYTES*8-1:0]   src_data,
    input  logic [NUM_SOURCES*COUNT_W-1:0]          src_count,
    output logic [NUM_SOURCES-1:0]                  src_taken,
    output logic [NUM_ENGINES*RECORD_BYTES*8-1:0]   eng_data,
    output logic [NUM_ENGINES*COUNT_W-1:0]          eng_count,
    output logic [NUM_ENGINES-1:0]                  eng_valid,
    input  logic [NUM_ENGINES-1:0]                  eng_ready,
    output logic [ENG_IDX_W-1:0]                    ord_engine,
    output logic                                    ord_valid,
    input  logic                                    ord_ready,
    output logic [15:0]                             oversize_drops,
    output logic [15:0]                             dispatched_total
);
    localparam int REC_W   = RECORD_BYTES * 8;
    localparam int SRC_W   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int FIFO_AW = (ORDER_FIFO_DEPTH > 1) ? $clog2(ORDER_FIFO_DEPTH) : 1;
    localparam logic [COUNT_W-1:0]   MAX_CNT   = COUNT_W'(RECORD_BYTES);
    localparam logic [SRC_W-1:0]     LAST_SRC  = SRC_W'(NUM_SOURCES - 1);
    localparam logic [ENG_IDX_W-1:0] LAST_ENG  = ENG_IDX_W'(NUM_ENGINES - 1);
    localparam logic [FIFO_AW:0]     FIFO_FULL = (FIFO_AW + 1)'(ORDER_FIFO_DEPTH);

    logic [SRC_W-1:0]     src_ptr_reg;
    logic [ENG_IDX_W-1:0] eng_ptr_reg;
    logic                 slot_valid_reg [NUM_ENGINES];
    logic [REC_W-1:0]     slot_data_reg  [NUM_ENGINES];
    logic [COUNT_W-1:0]   slot_count_reg [NUM_ENGINES];

    logic [ENG_IDX_W-1:0] fifo_mem [ORDER_FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]     fill_reg;

    logic [15:0] drops_reg, total_reg;

    logic [COUNT_W-1:0] cur_cnt;
    logic [REC_W-1:0]   cur_data;
    logic               slot_free, fifo_full, push, pop, fifo_ok, dispatch, drop;

    assign cur_cnt   = src_count[int'(src_ptr_reg)*COUNT_W +: COUNT_W];
    assign cur_data  = src_data[int'(src_ptr_reg)*REC_W +: REC_W];
    assign slot_free = !slot_valid_reg[eng_ptr_reg] || eng_ready[eng_ptr_reg];
    assign fifo_full = (fill_reg == FIFO_FULL);
    assign pop       = ord_valid && ord_ready;
    assign fifo_ok   = !fifo_full || pop;
    // Decisions are gated while reset is held so no source is strobed during reset.
    assign dispatch  = reset && (cur_cnt != '0) && (cur_cnt <= MAX_CNT) && slot_free && fifo_ok;
    assign drop      = reset && (cur_cnt > MAX_CNT);
    assign push      = dispatch;

    // Strobe the current source when its record is consumed (dispatched or dropped).
    always_comb begin
        src_taken = '0;
        if (dispatch || drop) begin
            src_taken[src_ptr_reg] = 1'b1;
        end
    end

    // Ring pointer over sources and round-robin pointer over engines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr_reg <= '0;
            eng_ptr_reg <= '0;
        end else begin
            if (dispatch || drop) begin
                src_ptr_reg <= (src_ptr_reg == LAST_SRC) ? '0 : src_ptr_reg + 1'b1;
            end
            if (dispatch) begin
                eng_ptr_reg <= (eng_ptr_reg == LAST_ENG) ? '0 : eng_ptr_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_slot
            // Engine output register: reload wins over a same-cycle transfer.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_data_reg[gi]  <= '0;
                    slot_count_reg[gi] <= '0;
                end else if (dispatch && (eng_ptr_reg == ENG_IDX_W'(gi))) begin
                    slot_valid_reg[gi] <= 1'b1;
                    slot_data_reg[gi]  <= cur_data;
                    slot_count_reg[gi] <= cur_cnt;
                end else if (eng_ready[gi]) begin
                    slot_valid_reg[gi] <= 1'b0;
                end
            end

            assign eng_valid[gi]                        = slot_valid_reg[gi];
            assign eng_data[gi*REC_W +: REC_W]          = slot_data_reg[gi];
            assign eng_count[gi*COUNT_W +: COUNT_W]     = slot_count_reg[gi];
        end
    endgenerate

    // Order FIFO storage; contents need no reset since fill_reg gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= eng_ptr_reg;
        end
    end

    // Order FIFO pointers and occupancy; push and pop may coincide even when full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      fill_reg <= fill_reg + 1'b1;
            else if (pop && !push) fill_reg <= fill_reg - 1'b1;
        end
    end

    assign ord_valid  = (fill_reg != '0);
    assign ord_engine = ord_valid ? fifo_mem[rd_ptr_reg] : '0;

    // Statistics: drops saturate, dispatches wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops_reg <= '0;
            total_reg <= '0;
        end else begin
            if (drop && (drops_reg != 16'hFFFF)) drops_reg <= drops_reg + 1'b1;
            if (dispatch)                        total_reg <= total_reg + 1'b1;
        end
    end

    assign oversize_drops   = drops_reg;
    assign dispatched_total = total_reg;

endmodule

// File: tb/tb_record_dispatcher.sv
// Directed bench for record_dispatcher: ring order, oversize drops, engine and
// order-FIFO backpressure, empty sources and mid-operation reset.
module tb_record_dispatcher;
    localparam int NS = 4;
    localparam int NE = 2;
    localparam int RB = 34;
    localparam int CW = 6;
    localparam int RW = RB * 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NS*RW-1:0]     src_data = '0;
    logic [NS*CW-1:0]     src_count = '0;
    logic [NS-1:0]        src_taken;
    logic [NE*RW-1:0]     eng_data;
    logic [NE*CW-1:0]     eng_count;
    logic [NE-1:0]        eng_valid;
    logic [NE-1:0]        eng_ready = '0;
    logic                 ord_engine;
    logic                 ord_valid;
    logic                 ord_ready = 1'b0;
    logic [15:0]          oversize_drops;
    logic [15:0]          dispatched_total;

    int checks = 0;
    int errors = 0;
    int refill [NS];

    record_dispatcher #(
        .NUM_SOURCES(NS), .NUM_ENGINES(NE), .RECORD_BYTES(RB),
        .COUNT_W(CW), .ORDER_FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset),
        .src_data(src_data), .src_count(src_count), .src_taken(src_taken),
        .eng_data(eng_data), .eng_count(eng_count), .eng_valid(eng_valid),
        .eng_ready(eng_ready), .ord_engine(ord_engine), .ord_valid(ord_valid),
        .ord_ready(ord_ready), .oversize_drops(oversize_drops),
        .dispatched_total(dispatched_total)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] rec(input int i);
        logic [RW-1:0] r;
        for (int b = 0; b < RB; b++) r[b*8 +: 8] = 8'((i << 4) + b);
        return r;
    endfunction

    function automatic logic [RW-1:0] eng_rec(input int e);
        return eng_data[e*RW +: RW];
    endfunction

    task automatic set_cnt(input int i, input int c);
        src_count[i*CW +: CW] = CW'(c);
    endtask

    // One clock: sources that were strobed present their refill value (or nothing).
    task automatic tick();
        logic [NS-1:0] taken;
        taken = src_taken;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) if (taken[i]) set_cnt(i, refill[i]);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin
            refill[i] = 0;
            set_cnt(i, 0);
            src_data[i*RW +: RW] = rec(i);
        end
        eng_ready = '0;
        ord_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin
            set_cnt(i, 9);
            src_data[i*RW +: RW] = rec(i);
        end
        eng_ready = '1;
        ord_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (src_taken !== 4'b0000) begin errors++; $display("FAIL reset_taken got %b exp 0000", src_taken); end
        checks++;
        if (eng_valid !== 2'b00 || ord_valid !== 1'b0 || ord_engine !== 1'b0) begin
            errors++; $display("FAIL reset_valids got eng_valid=%b ord_valid=%b ord_engine=%b exp 00/0/0", eng_valid, ord_valid, ord_engine);
        end
        checks++;
        if (eng_data !== '0 || eng_count !== '0) begin errors++; $display("FAIL reset_eng_data got count=%h exp 0", eng_count); end
        checks++;
        if (oversize_drops !== 16'd0 || dispatched_total !== 16'd0) begin
            errors++; $display("FAIL reset_counters got drops=%0d total=%0d exp 0/0", oversize_drops, dispatched_total);
        end
    endtask

    task automatic test_ring();
        do_reset();
        for (int i = 0; i < NS; i++) set_cnt(i, 9);
        eng_ready = '1;
        ord_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (src_taken !== 4'(1 << k)) begin errors++; $display("FAIL ring_taken%0d got %b exp %b", k, src_taken, 4'(1 << k)); end
            tick();
            checks++;
            if (eng_valid[k%2] !== 1'b1 || eng_rec(k%2) !== rec(k) || eng_count[(k%2)*CW +: CW] !== 6'd9) begin
                errors++; $display("FAIL ring_engine%0d got valid=%b count=%0d exp valid=1 count=9 data of src %0d", k, eng_valid, eng_count[(k%2)*CW +: CW], k);
            end
            checks++;
            if (ord_valid !== 1'b1 || ord_engine !== 1'(k % 2)) begin
                errors++; $display("FAIL ring_ord%0d got valid=%b engine=%0d exp 1/%0d", k, ord_valid, ord_engine, k % 2);
            end
        end
        checks++;
        if (dispatched_total !== 16'd4 || src_taken !== 4'b0000) begin
            errors++; $display("FAIL ring_total got %0d taken=%b exp 4/0000", dispatched_total, src_taken);
        end
        tick();
        checks++;
        if (ord_valid !== 1'b0 || eng_valid !== 2'b00) begin
            errors++; $display("FAIL ring_drain got ord_valid=%b eng_valid=%b exp 0/00", ord_valid, eng_valid);
        end
    endtask

    task automatic test_oversize();
        logic exp_head [3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        set_cnt(0, 10); set_cnt(1, 40); set_cnt(2, 10); set_cnt(3, 10);
        eng_ready = '1;
        #1;
        checks++;
        if (src_taken !== 4'b0001) begin errors++; $display("FAIL ovs_taken0 got %b exp 0001", src_taken); end
        tick();
        checks++;
        if (src_taken !== 4'b0010) begin errors++; $display("FAIL ovs_drop_taken got %b exp 0010", src_taken); end
        tick();
        checks++;
        if (oversize_drops !== 16'd1 || dispatched_total !== 16'd1) begin
            errors++; $display("FAIL ovs_counters got drops=%0d total=%0d exp 1/1", oversize_drops, dispatched_total);
        end
        checks++;
        if (src_taken !== 4'b0100) begin errors++; $display("FAIL ovs_taken2 got %b exp 0100", src_taken); end
        tick();
        checks++;
        if (eng_valid[1] !== 1'b1 || eng_rec(1) !== rec(2)) begin
            errors++; $display("FAIL ovs_src2_engine1 got valid=%b count=%0d exp valid=1 data of src 2", eng_valid[1], eng_count[CW +: CW]);
        end
        tick();
        checks++;
        if (eng_rec(0) !== rec(3) || dispatched_total !== 16'd3) begin
            errors++; $display("FAIL ovs_src3_engine0 got total=%0d exp 3 with data of src 3", dispatched_total);
        end
        ord_ready = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (ord_valid !== 1'b1 || ord_engine !== exp_head[j]) begin
                errors++; $display("FAIL ovs_fifo%0d got valid=%b engine=%0d exp 1/%0d", j, ord_valid, ord_engine, exp_head[j]);
            end
            tick();
        end
        checks++;
        if (ord_valid !== 1'b0) begin errors++; $display("FAIL ovs_fifo_empty got %b exp 0", ord_valid); end
    endtask

    task automatic test_eng_stall();
        do_reset();
        for (int i = 0; i < NS; i++) set_cnt(i, 9);
        eng_ready = 2'b01;
        ord_ready = 1'b1;
        #1;
        checks++;
        if (src_taken !== 4'b0001) begin errors++; $display("FAIL stall_taken0 got %b exp 0001", src_taken); end
        tick();
        checks++;
        if (src_taken !== 4'b0010) begin errors++; $display("FAIL stall_taken1 got %b exp 0010", src_taken); end
        tick();
        checks++;
        if (eng_valid[1] !== 1'b1 || eng_rec(1) !== rec(1)) begin errors++; $display("FAIL stall_load1 got valid=%b exp 1 with src 1 data", eng_valid[1]); end
        checks++;
        if (src_taken !== 4'b0100) begin errors++; $display("FAIL stall_taken2 got %b exp 0100", src_taken); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (src_taken !== 4'b0000) begin errors++; $display("FAIL stall_blocked%0d got %b exp 0000", k, src_taken); end
            tick();
            checks++;
            if (eng_valid[1] !== 1'b1 || eng_rec(1) !== rec(1)) begin
                errors++; $display("FAIL stall_hold%0d got valid=%b exp slot 1 held with src 1 data", k, eng_valid[1]);
            end
        end
        eng_ready = 2'b11;
        #1;
        checks++;
        if (src_taken !== 4'b1000) begin errors++; $display("FAIL stall_release got %b exp 1000", src_taken); end
        tick();
        checks++;
        if (eng_valid[1] !== 1'b1 || eng_rec(1) !== rec(3) || dispatched_total !== 16'd4) begin
            errors++; $display("FAIL stall_reload got valid=%b total=%0d exp 1/4 with src 3 data", eng_valid[1], dispatched_total);
        end
    endtask

    task automatic test_fifo_full();
        int n;
        do_reset();
        for (int i = 0; i < NS; i++) begin set_cnt(i, 9); refill[i] = 9; end
        eng_ready = '1;
        #1;
        n = 0;
        repeat (12) begin
            if (src_taken !== 4'b0000) n++;
            tick();
        end
        checks++;
        if (n != 8 || dispatched_total !== 16'd8) begin errors++; $display("FAIL full_count got n=%0d total=%0d exp 8/8", n, dispatched_total); end
        checks++;
        if (src_taken !== 4'b0000 || ord_valid !== 1'b1 || ord_engine !== 1'b0) begin
            errors++; $display("FAIL full_stall got taken=%b ord_valid=%b engine=%0d exp 0000/1/0", src_taken, ord_valid, ord_engine);
        end
        ord_ready = 1'b1;
        #1;
        checks++;
        if (src_taken !== 4'b0001) begin errors++; $display("FAIL full_pushpop_taken got %b exp 0001", src_taken); end
        tick();
        ord_ready = 1'b0;
        #1;
        checks++;
        if (dispatched_total !== 16'd9 || ord_engine !== 1'b1) begin
            errors++; $display("FAIL full_pushpop got total=%0d head=%0d exp 9/1", dispatched_total, ord_engine);
        end
        n = 0;
        repeat (4) begin
            if (src_taken !== 4'b0000) n++;
            tick();
        end
        checks++;
        if (n != 0 || dispatched_total !== 16'd9) begin errors++; $display("FAIL full_restall got n=%0d total=%0d exp 0/9", n, dispatched_total); end
    endtask

    task automatic test_zero_count();
        do_reset();
        set_cnt(0, 0); set_cnt(1, 9); set_cnt(2, 9); set_cnt(3, 9);
        eng_ready = '1;
        ord_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (src_taken !== 4'b0000) begin errors++; $display("FAIL zero_hold%0d got %b exp 0000", k, src_taken); end
            tick();
        end
        checks++;
        if (dispatched_total !== 16'd0) begin errors++; $display("FAIL zero_total got %0d exp 0", dispatched_total); end
        set_cnt(0, 9);
        #1;
        checks++;
        if (src_taken !== 4'b0001) begin errors++; $display("FAIL zero_resume got %b exp 0001", src_taken); end
        tick();
        checks++;
        if (src_taken !== 4'b0010 || eng_rec(0) !== rec(0)) begin
            errors++; $display("FAIL zero_next got %b exp 0010 with src 0 data in engine 0", src_taken);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NS; i++) begin set_cnt(i, 9); refill[i] = 9; end
        eng_ready = '1;
        #1;
        repeat (4) tick();
        eng_ready = '0;
        tick();
        checks++;
        if (eng_valid !== 2'b11 || ord_valid !== 1'b1 || dispatched_total !== 16'd5) begin
            errors++; $display("FAIL mid_prep got eng_valid=%b ord_valid=%b total=%0d exp 11/1/5", eng_valid, ord_valid, dispatched_total);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (eng_valid !== 2'b00 || ord_valid !== 1'b0 || ord_engine !== 1'b0) begin
            errors++; $display("FAIL mid_async_clear got eng_valid=%b ord_valid=%b engine=%0d exp 00/0/0", eng_valid, ord_valid, ord_engine);
        end
        checks++;
        if (dispatched_total !== 16'd0 || oversize_drops !== 16'd0 || src_taken !== 4'b0000) begin
            errors++; $display("FAIL mid_counters got total=%0d drops=%0d taken=%b exp 0/0/0000", dispatched_total, oversize_drops, src_taken);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        eng_ready = '1;
        #1;
        checks++;
        if (src_taken !== 4'b0001) begin errors++; $display("FAIL mid_first_taken got %b exp 0001", src_taken); end
        tick();
        checks++;
        if (eng_valid !== 2'b01 || eng_rec(0) !== rec(0) || ord_engine !== 1'b0 || ord_valid !== 1'b1) begin
            errors++; $display("FAIL mid_first_dispatch got eng_valid=%b ord=%b/%0d exp 01/1/0 with src 0 data", eng_valid, ord_valid, ord_engine);
        end
    endtask

    initial begin
        test_reset();
        test_ring();
        test_oversize();
        test_eng_stall();
        test_fifo_full();
        test_zero_count();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
